// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the 0111 sequence detector: WIDTH-bit words in, one bit per clock out.
// Optional even-parity trailer bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {StIdle, StShift} state_t;

    state_t               r_state;
    logic [FRAME_LEN-1:0] r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ser_out;
    logic                 r_ser_valid;
    logic                 r_frame_done;

    logic [FRAME_LEN-1:0] w_frame;
    logic [FRAME_LEN-1:0] w_load_rest;
    logic [FRAME_LEN-1:0] w_shift_rest;
    logic                 w_load_first;
    logic                 w_shift_next;
    logic                 w_accept;

    // Parity sits at the tail of the frame whichever end is shifted first.
    always_comb begin
`ifdef BIT_SERIALIZER_PARITY_EN
        if (MSB_FIRST) begin
            w_frame = {load_data, ^load_data};
        end else begin
            w_frame = {^load_data, load_data};
        end
`else
        w_frame = load_data;
`endif
    end

    always_comb begin
        if (MSB_FIRST) begin
            w_load_first = w_frame[FRAME_LEN-1];
            w_load_rest  = w_frame << 1;
            w_shift_next = r_shift[FRAME_LEN-1];
            w_shift_rest = r_shift << 1;
        end else begin
            w_load_first = w_frame[0];
            w_load_rest  = w_frame >> 1;
            w_shift_next = r_shift[0];
            w_shift_rest = r_shift >> 1;
        end
    end

    // Ready in IDLE and during the last bit, so back-to-back words leave no bubble.
    assign load_ready = rst && ((r_state == StIdle) || (r_cnt == '0));
    assign w_accept   = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_ser_out    <= IDLE_BIT;
            r_ser_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state      <= StShift;
                r_shift      <= w_load_rest;
                r_cnt        <= CNT_LAST;
                r_ser_out    <= w_load_first;
                r_ser_valid  <= 1'b1;
                r_frame_done <= 1'b0;
            end else begin
                case (r_state)
                    StShift: begin
                        if (r_cnt == '0) begin
                            r_state      <= StIdle;
                            r_ser_out    <= IDLE_BIT;
                            r_ser_valid  <= 1'b0;
                            r_frame_done <= 1'b0;
                        end else begin
                            r_cnt        <= r_cnt - 1'b1;
                            r_shift      <= w_shift_rest;
                            r_ser_out    <= w_shift_next;
                            r_ser_valid  <= 1'b1;
                            r_frame_done <= (r_cnt == CNT_W'(1));
                        end
                    end
                    default: begin
                        r_state      <= StIdle;
                        r_ser_out    <= IDLE_BIT;
                        r_ser_valid  <= 1'b0;
                        r_frame_done <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == StShift);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances checked against a bit-queue model.
module tb_bit_serializer;
    localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         rdy0, so0, sv0, fd0, bz0;
    logic         rdy1, so1, sv1, fd1, bz1;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   q0[$];
    bit   q1[$];
    bit   acc_last;
    int   det_hits;
    logic [3:0] det_hist;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (rdy0),
        .ser_out    (so0),
        .ser_valid  (sv0),
        .frame_done (fd0),
        .busy       (bz0)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (rdy1),
        .ser_out    (so1),
        .ser_valid  (sv1),
        .frame_done (fd1),
        .busy       (bz1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each frame is just the list of bits the wire should carry, in order.
    task automatic push_frame(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            q0.push_back(d[W-1-i]);
            q1.push_back(d[i]);
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        q0.push_back(^d);
        q1.push_back(^d);
`endif
    endtask

    task automatic tick();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = rst && (q0.size() <= 1);
        check("load_ready_msb", {31'd0, rdy0}, {31'd0, exp_rdy});
        check("load_ready_lsb", {31'd0, rdy1}, {31'd0, exp_rdy});
        check("ser_valid_msb", {31'd0, sv0}, {31'd0, q0.size() != 0});
        check("ser_valid_lsb", {31'd0, sv1}, {31'd0, q1.size() != 0});
        check("ser_out_msb", {31'd0, so0}, {31'd0, (q0.size() != 0) ? q0[0] : 1'b0});
        check("ser_out_lsb", {31'd0, so1}, {31'd0, (q1.size() != 0) ? q1[0] : 1'b0});
        check("frame_done_msb", {31'd0, fd0}, {31'd0, q0.size() == 1});
        check("frame_done_lsb", {31'd0, fd1}, {31'd0, q1.size() == 1});
        check("busy_msb", {31'd0, bz0}, {31'd0, q0.size() != 0});
        check("busy_lsb", {31'd0, bz1}, {31'd0, q1.size() != 0});
        if (sv0) begin
            det_hist = {det_hist[2:0], so0};
            if (det_hist == 4'b0111) det_hits++;
        end
        acc_last = load_valid && exp_rdy;
        @(posedge clk);
        if (q0.size() != 0) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (acc_last) push_frame(load_data);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        acc_last   = 1'b0;
        for (int k = 0; k < 4 * FL && !acc_last; k++) tick();
        check("accept_in_budget", {31'd0, acc_last}, 32'd1);
        load_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * FL && q0.size() != 0; k++) tick();
        tick();
    endtask

    initial begin
        det_hits = 0;
        det_hist = 4'b1111;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single 8'h77 frame; a 0111 detector on the stream fires twice.
        send_word(8'h77);
        drain();
        check("detector_hits_77", det_hits, 32'd2);

        // Back-to-back frames with load_valid held.
        send_word(8'h0F);
        send_word(8'hF0);
        drain();

        // 8'hA5 offered while 8'h3C is in flight waits for the last bit.
        send_word(8'h3C);
        send_word(8'hA5);
        tick();
        tick();
        tick();

        // Asynchronous reset mid-frame, away from the clock edge.
        #1;
        rst = 1'b0;
        #1;
        check("rst_ser_valid", {31'd0, sv0}, 32'd0);
        check("rst_ser_out", {31'd0, so0}, 32'd0);
        check("rst_busy", {31'd0, bz0}, 32'd0);
        check("rst_load_ready", {31'd0, rdy0}, 32'd0);
        check("rst_busy_lsb", {31'd0, bz1}, 32'd0);
        q0.delete();
        q1.delete();
        tick();
        tick();
        #2;
        rst = 1'b1;
        tick();
        send_word(8'h01);
        drain();

        // Random valid/data traffic, including valid dropping before accept.
        for (int c = 0; c < 300; c++) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = W'($urandom);
            tick();
        end
        load_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
